// File: rtl/vga2048_pkg.sv
// Shared constants and types for the VGA-2048 display path.
package vga2048_pkg;

  localparam int unsigned H0_DEF  = 260;
  localparam int unsigned V0_DEF  = 70;
  localparam int unsigned CELL    = 100;
  localparam int unsigned GAP_DEF = 4;

  localparam int unsigned EXP_W  = 4;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned TILES  = 16;

  localparam logic [7:0] FRAME_COLOR = 8'hB6;
  localparam logic [7:0] EMPTY_COLOR = 8'hDB;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } commit_state_e;

endpackage

// File: rtl/tile_palette.sv
// Fixed exponent-to-colour lookup for 2048 tiles, RGB332 output.
module tile_palette
  import vga2048_pkg::*;
(
  input  logic [EXP_W-1:0] tile_exp,
  output logic [7:0]       color
);

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    color = 8'h49;
    case (tile_exp)
      4'd0:  color = EMPTY_COLOR;
      4'd1:  color = 8'hFC;
      4'd2:  color = 8'hF8;
      4'd3:  color = 8'hF4;
      4'd4:  color = 8'hEC;
      4'd5:  color = 8'hE4;
      4'd6:  color = 8'hE0;
      4'd7:  color = 8'hFD;
      4'd8:  color = 8'hF9;
      4'd9:  color = 8'hF5;
      4'd10: color = 8'hF1;
      4'd11: color = 8'hED;
      default: color = 8'h49;
    endcase
  end

endmodule

// File: rtl/tile_renderer.sv
// Pixel-colour stage: double-buffered 4x4 board, frame-start commit, 2-cycle pixel pipeline.
module tile_renderer
  import vga2048_pkg::*;
#(
  parameter int unsigned H0  = H0_DEF,
  parameter int unsigned V0  = V0_DEF,
  parameter int unsigned GAP = GAP_DEF
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [9:0]        count_h,
  input  logic [9:0]        count_v,
  input  logic [1:0]        num_h,
  input  logic [1:0]        num_v,
  input  logic              flag,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [EXP_W-1:0]  wr_data,
  input  logic              commit_req,
  output logic              commit_ack,
  output logic              pending,
  output logic [7:0]        rgb,
  output logic              hsync_out,
  output logic              vsync_out
);

  localparam logic [10:0] H0_W   = 11'(H0);
  localparam logic [10:0] V0_W   = 11'(V0);
  localparam logic [10:0] GAP_W  = 11'(GAP);
  localparam logic [10:0] CELL_W = 11'(CELL);
  localparam logic [10:0] SPAN_W = 11'(4 * CELL);

  logic [EXP_W-1:0] shadow [TILES];
  logic [EXP_W-1:0] active [TILES];
  commit_state_e    state;
  logic             swap;

  assign swap       = (count_h == '0) && (count_v == '0) && (state == ST_PENDING);
  assign pending    = (state == ST_PENDING);
  assign commit_ack = swap;

  // NOTE: the banks are reset explicitly because the board must read all-empty straight out of reset.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < TILES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking here makes the swap copy the pre-write shadow even when wr_en hits the same cycle.
      if (wr_en) shadow[wr_addr] <= wr_data;
      if (swap) begin
        for (int i = 0; i < TILES; i++) active[i] <= shadow[i];
      end
    end
  end

  // A request landing on the swap cycle is dropped rather than queued.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (commit_req) state <= ST_PENDING;
        ST_PENDING: if (swap) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  logic [10:0] ch, cv, cell_x, cell_y;
  logic        in_tile_d;

  assign ch     = {1'b0, count_h};
  assign cv     = {1'b0, count_v};
  assign cell_x = H0_W + CELL_W * {9'b0, num_h};
  assign cell_y = V0_W + CELL_W * {9'b0, num_v};

  assign in_tile_d = (ch > cell_x + GAP_W) && (ch <= cell_x + CELL_W - GAP_W) &&
                     (cv > cell_y + GAP_W) && (cv <= cell_y + CELL_W - GAP_W) &&
                     (ch > H0_W) && (ch <= H0_W + SPAN_W) &&
                     (cv > V0_W) && (cv <= V0_W + SPAN_W);

  logic [ADDR_W-1:0] idx_q;
  logic              flag_q, in_tile_q, hs_q, vs_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      idx_q     <= '0;
      flag_q    <= 1'b0;
      in_tile_q <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      idx_q     <= {num_v, num_h};
      flag_q    <= flag;
      in_tile_q <= in_tile_d;
      hs_q      <= hsync_in;
      vs_q      <= vsync_in;
    end
  end

  logic [EXP_W-1:0] tile_exp;
  logic [7:0]       tile_color, pix_d;

  assign tile_exp = active[idx_q];

  tile_palette u_palette (
    .tile_exp (tile_exp),
    .color    (tile_color)
  );

  always_comb begin
    pix_d = 8'h00;
    if (flag_q) begin
      if (!in_tile_q)           pix_d = FRAME_COLOR;
      else if (tile_exp == '0)  pix_d = EMPTY_COLOR;
      else                      pix_d = tile_color;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rgb       <= 8'h00;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      rgb       <= pix_d;
      hsync_out <= hs_q;
      vsync_out <= vs_q;
    end
  end

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer: board colours, gaps, commit handshake, sync alignment, reset.
module tb_tile_renderer;
  import vga2048_pkg::*;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [9:0] count_h, count_v;
  logic [1:0] num_h, num_v;
  logic       flag, hsync_in, vsync_in;
  logic       wr_en;
  logic [3:0] wr_addr, wr_data;
  logic       commit_req, commit_ack, pending;
  logic [7:0] rgb;
  logic       hsync_out, vsync_out;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         h;
    int         v;
    logic [7:0] want;
  } pix_t;

  typedef struct {
    int         h;
    int         v;
    logic       hs;
    logic       vs;
    logic [7:0] want;
  } beat_t;

  tile_renderer dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .count_h    (count_h),
    .count_v    (count_v),
    .num_h      (num_h),
    .num_v      (num_v),
    .flag       (flag),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit_req (commit_req),
    .commit_ack (commit_ack),
    .pending    (pending),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out)
  );

  always #5 clk = ~clk;

  // Cell index as the timing generator reports it: cell k spans (org+100k, org+100k+100].
  function automatic logic [1:0] cell_of(input int c, input int org);
    int k;
    if (c <= org) return 2'd0;
    k = (c - org - 1) / 100;
    if (k > 3) k = 3;
    return 2'(k);
  endfunction

  task automatic set_pixel(input int h, input int v);
    count_h = 10'(h);
    count_v = 10'(v);
    num_h   = cell_of(h, 260);
    num_v   = cell_of(v, 70);
    flag    = (h > 260) && (h <= 660) && (v > 70) && (v <= 470);
  endtask

  task automatic pix(input int h, input int v, output logic [7:0] got);
    set_pixel(h, v);
    repeat (2) @(posedge clk);
    #1 got = rgb;
  endtask

  task automatic write_tile(input logic [3:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic request_commit();
    set_pixel(300, 200);
    commit_req = 1'b1;
    @(posedge clk); #1;
    commit_req = 1'b0;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    #1;
    n_tests++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL reset_rgb: got %h want 00", rgb); end
    n_tests++; if (hsync_out !== 1'b0) begin n_fail++; $display("FAIL reset_hsync: got %b want 0", hsync_out); end
    n_tests++; if (vsync_out !== 1'b0) begin n_fail++; $display("FAIL reset_vsync: got %b want 0", vsync_out); end
    n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", pending); end
    n_tests++; if (commit_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", commit_ack); end
    @(posedge clk); #1;
    clr_n = 1'b1;
  endtask

  task automatic test_blank_board();
    pix_t       tab [9];
    logic [7:0] got;
    tab = '{'{262, 100, 8'hB6}, '{300, 100, 8'hDB}, '{100, 100, 8'h00},
            '{660, 470, 8'hB6}, '{661, 300, 8'h00}, '{400, 220, 8'hDB},
            '{610, 420, 8'hDB}, '{365, 175, 8'hDB}, '{364, 175, 8'hB6}};
    foreach (tab[i]) begin
      pix(tab[i].h, tab[i].v, got);
      n_tests++;
      if (got !== tab[i].want) begin
        n_fail++;
        $display("FAIL blank_board(%0d,%0d): got %h want %h", tab[i].h, tab[i].v, got, tab[i].want);
      end
    end
  endtask

  // Streams one pixel per clock; rgb and both syncs must reappear together 2 cycles later.
  task automatic test_stream_sync();
    beat_t t [8];
    t = '{'{262, 100, 1'b1, 1'b0, 8'hB6}, '{300, 100, 1'b1, 1'b0, 8'hDB},
          '{100, 100, 1'b0, 1'b0, 8'h00}, '{400, 220, 1'b0, 1'b1, 8'hDB},
          '{364, 220, 1'b1, 1'b1, 8'hB6}, '{700,  50, 1'b0, 1'b0, 8'h00},
          '{510, 420, 1'b1, 1'b0, 8'hDB}, '{660, 470, 1'b0, 1'b1, 8'hB6}};
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        n_tests++;
        if (rgb !== t[i-2].want) begin n_fail++; $display("FAIL stream_rgb[%0d]: got %h want %h", i-2, rgb, t[i-2].want); end
        n_tests++;
        if (hsync_out !== t[i-2].hs) begin n_fail++; $display("FAIL stream_hsync[%0d]: got %b want %b", i-2, hsync_out, t[i-2].hs); end
        n_tests++;
        if (vsync_out !== t[i-2].vs) begin n_fail++; $display("FAIL stream_vsync[%0d]: got %b want %b", i-2, vsync_out, t[i-2].vs); end
      end
      if (i < 8) begin
        set_pixel(t[i].h, t[i].v);
        hsync_in = t[i].hs;
        vsync_in = t[i].vs;
      end
      @(posedge clk); #1;
    end
    hsync_in = 1'b0;
    vsync_in = 1'b0;
  endtask

  task automatic test_commit();
    logic [7:0] got;
    set_pixel(300, 200);
    write_tile(4'd5, 4'd11);
    n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL commit_write_only_pending: got %b want 0", pending); end
    request_commit();
    n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL commit_pending_set: got %b want 1", pending); end
    pix(400, 220, got);
    n_tests++; if (got !== 8'hDB) begin n_fail++; $display("FAIL commit_old_frame: got %h want DB", got); end
    n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL commit_pending_hold: got %b want 1", pending); end
    set_pixel(0, 0);
    #1;
    n_tests++; if (commit_ack !== 1'b1) begin n_fail++; $display("FAIL commit_ack_pulse: got %b want 1", commit_ack); end
    @(posedge clk); #1;
    n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL commit_pending_clear: got %b want 0", pending); end
    n_tests++; if (commit_ack !== 1'b0) begin n_fail++; $display("FAIL commit_ack_single: got %b want 0", commit_ack); end
    pix(400, 220, got);
    n_tests++; if (got !== 8'hED) begin n_fail++; $display("FAIL commit_new_frame: got %h want ED", got); end
  endtask

  task automatic test_swap_write();
    logic [7:0] got;
    write_tile(4'd2, 4'd12);
    write_tile(4'd15, 4'd7);
    request_commit();
    set_pixel(0, 0);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'd3;
    #1;
    n_tests++; if (commit_ack !== 1'b1) begin n_fail++; $display("FAIL swapwr_ack: got %b want 1", commit_ack); end
    @(posedge clk); #1;
    wr_en = 1'b0;
    pix(300, 100, got);
    n_tests++; if (got !== 8'hDB) begin n_fail++; $display("FAIL swapwr_tile0_old: got %h want DB", got); end
    pix(510, 120, got);
    n_tests++; if (got !== 8'h49) begin n_fail++; $display("FAIL swapwr_tile2_exp12: got %h want 49", got); end
    pix(610, 420, got);
    n_tests++; if (got !== 8'hFD) begin n_fail++; $display("FAIL swapwr_tile15_exp7: got %h want FD", got); end
    pix(400, 220, got);
    n_tests++; if (got !== 8'hED) begin n_fail++; $display("FAIL swapwr_tile5_kept: got %h want ED", got); end
    request_commit();
    set_pixel(0, 0);
    @(posedge clk); #1;
    pix(300, 100, got);
    n_tests++; if (got !== 8'hF4) begin n_fail++; $display("FAIL swapwr_tile0_new: got %h want F4", got); end
  endtask

  task automatic test_gap_edges();
    pix_t       tab [9];
    logic [7:0] got;
    tab = '{'{264, 100, 8'hB6}, '{265, 100, 8'hF4}, '{356, 100, 8'hF4},
            '{357, 100, 8'hB6}, '{360, 100, 8'hB6}, '{300,  74, 8'hB6},
            '{300,  75, 8'hF4}, '{300, 166, 8'hF4}, '{300, 167, 8'hB6}};
    foreach (tab[i]) begin
      pix(tab[i].h, tab[i].v, got);
      n_tests++;
      if (got !== tab[i].want) begin
        n_fail++;
        $display("FAIL gap_edge(%0d,%0d): got %h want %h", tab[i].h, tab[i].v, got, tab[i].want);
      end
    end
  endtask

  task automatic test_held_req();
    int acks;
    set_pixel(300, 300);
    commit_req = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL held_pending_set: got %b want 1", pending); end
    set_pixel(0, 0);
    #1;
    acks = int'(commit_ack);
    @(posedge clk); #1;
    commit_req = 1'b0;
    set_pixel(5, 0);
    n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL held_pending_clear: got %b want 0", pending); end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) set_pixel(0, 0); else set_pixel(10 + i, 0);
      #1;
      acks += int'(commit_ack);
      @(posedge clk); #1;
    end
    n_tests++; if (acks !== 1) begin n_fail++; $display("FAIL held_ack_count: got %0d want 1", acks); end
    n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL held_no_requeue: got %b want 0", pending); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] got;
    request_commit();
    set_pixel(400, 300);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (rgb !== 8'hDB) begin n_fail++; $display("FAIL midrst_pre_rgb: got %h want DB", rgb); end
    n_tests++; if (hsync_out !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_hsync: got %b want 1", hsync_out); end
    #2 clr_n = 1'b0;
    #1;
    n_tests++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL midrst_rgb: got %h want 00", rgb); end
    n_tests++; if (hsync_out !== 1'b0) begin n_fail++; $display("FAIL midrst_hsync: got %b want 0", hsync_out); end
    n_tests++; if (vsync_out !== 1'b0) begin n_fail++; $display("FAIL midrst_vsync: got %b want 0", vsync_out); end
    n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL midrst_pending: got %b want 0", pending); end
    n_tests++; if (commit_ack !== 1'b0) begin n_fail++; $display("FAIL midrst_ack: got %b want 0", commit_ack); end
    @(posedge clk); #1;
    clr_n    = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    pix(400, 220, got);
    n_tests++; if (got !== 8'hDB) begin n_fail++; $display("FAIL midrst_tile5_empty: got %h want DB", got); end
    pix(300, 100, got);
    n_tests++; if (got !== 8'hDB) begin n_fail++; $display("FAIL midrst_tile0_empty: got %h want DB", got); end
    pix(510, 120, got);
    n_tests++; if (got !== 8'hDB) begin n_fail++; $display("FAIL midrst_tile2_empty: got %h want DB", got); end
    n_tests++; if (hsync_out !== 1'b0) begin n_fail++; $display("FAIL midrst_hsync_refill: got %b want 0", hsync_out); end
  endtask

  initial begin
    clr_n      = 1'b0;
    hsync_in   = 1'b0;
    vsync_in   = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    commit_req = 1'b0;
    set_pixel(1, 1);
    test_reset();
    test_blank_board();
    test_stream_sync();
    test_commit();
    test_swap_write();
    test_gap_edges();
    test_held_req();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
